// File: rtl/deserializador_pkg.sv
// Shared types and constants for the deserializador_bits capture stage.
package deserializador_pkg;

  localparam int unsigned WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    LLENANDO = 2'd0,
    PARIDAD  = 2'd1,
    LLENO    = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_bits.sv
// Modulo-MODULO bit counter with enable, synchronous load-to-1 and a wrap pulse.
module contador_bits
  import deserializador_pkg::*;
#(
  parameter  int unsigned MODULO = WIDTH_DEF,
  localparam int unsigned CW     = $clog2(MODULO + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          carga1_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_c_o
);

  logic [CW-1:0] cnt_q;

  assign wrap_c_o = en_i & (cnt_q == CW'(MODULO - 1));
  assign cnt_o    = cnt_q;

  // Load-to-1 wins: it marks the first bit of a word accepted during handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (carga1_i) begin
      cnt_q <= CW'(1);
    end else if (en_i) begin
      cnt_q <= wrap_c_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/deserializador_bits.sv
// Serial-to-parallel capture with valid/ready on both sides and a held output word.
// Optional trailing even-parity bit enabled by macro DESERIALIZADOR_PARITY_EN.
module deserializador_bits
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  output logic             palabra_valid,
  input  logic             palabra_ready,
  output logic             salidaBit,
  output logic [WIDTH-2:0] salidaNumBinario,
  output logic             error_paridad
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  estado_t          estado_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] palabra_q;
  logic             valid_q;
  logic [WIDTH-1:0] palabra_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx_d;
  logic             wrap;
  logic             acepta;
  logic             escribe;

  assign entrada_ready = (estado_q != LLENO) | palabra_ready;
  assign acepta        = entrada_valid & entrada_ready;
  assign escribe       = acepta & (estado_q != PARIDAD);
  assign idx_d         = (MSB_FIRST != 0) ? CW'(WIDTH - 1) - cnt : cnt;

  contador_bits #(.MODULO(WIDTH)) u_contador (
    .clk      (clk),
    .rst      (rst),
    .en_i     (acepta & (estado_q == LLENANDO)),
    .carga1_i (acepta & (estado_q == LLENO)),
    .cnt_o    (cnt),
    .wrap_c_o (wrap)
  );

  // Shift register contents with the incoming data bit merged in.
  always_comb begin
    palabra_d = shreg_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (escribe && (CW'(i) == idx_d)) palabra_d[i] = entrada;
    end
  end

`ifdef DESERIALIZADOR_PARITY_EN
  logic err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= LLENANDO;
      shreg_q   <= '0;
      palabra_q <= '0;
      valid_q   <= 1'b0;
`ifdef DESERIALIZADOR_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (escribe) shreg_q <= palabra_d;
      case (estado_q)
        LLENANDO: begin
          if (wrap) begin
`ifdef DESERIALIZADOR_PARITY_EN
            estado_q <= PARIDAD;
`else
            estado_q  <= LLENO;
            palabra_q <= palabra_d;
            valid_q   <= 1'b1;
`endif
          end
        end
`ifdef DESERIALIZADOR_PARITY_EN
        PARIDAD: begin
          if (acepta) begin
            estado_q  <= LLENO;
            palabra_q <= shreg_q;
            valid_q   <= 1'b1;
            err_q     <= (^shreg_q) ^ entrada;
          end
        end
`endif
        LLENO: begin
          if (palabra_ready) begin
            estado_q <= LLENANDO;
            valid_q  <= 1'b0;
          end
        end
        default: estado_q <= LLENANDO;
      endcase
    end
  end

  assign palabra_valid    = valid_q;
  assign salidaBit        = palabra_q[WIDTH-1];
  assign salidaNumBinario = palabra_q[WIDTH-2:0];
`ifdef DESERIALIZADOR_PARITY_EN
  assign error_paridad    = err_q;
`else
  assign error_paridad    = 1'b0;
`endif

endmodule
